// File: rtl/mcu_uart_pkg.sv
// Shared constants, state encodings and helpers for the memory-mapped UART.
package mcu_uart_pkg;

  // Register byte offsets; only bits [3:2] are decoded.
  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_RXDATA = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;
  localparam logic [3:0] OFF_DIV    = 4'hC;

  // STATUS register bit positions.
  localparam int unsigned ST_TX_FULL     = 0;
  localparam int unsigned ST_TX_EMPTY    = 1;
  localparam int unsigned ST_TX_BUSY     = 2;
  localparam int unsigned ST_RX_VALID    = 3;
  localparam int unsigned ST_RX_OVERRUN  = 4;
  localparam int unsigned ST_TX_OVERFLOW = 5;
  localparam int unsigned ST_FRAME_ERR   = 6;

  // Smallest divisor the bit timers accept; smaller DIV values are clamped.
  localparam logic [15:0] DIV_MIN = 16'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/mcu_uart_fifo.sv
// Byte-wide synchronous FIFO for the transmit path. Pushes when full are ignored.
module mcu_uart_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [7:0] wdata_i,
  input  logic       pop_i,
  output logic [7:0] rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // Pointer update; guarded so over/underflow never corrupts state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i && !full_o)  wptr_q <= wptr_q + 1'b1;
      if (pop_i  && !empty_o) rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/mcu_uart.sv
// 8N1 UART on the MCU data bus: TX FIFO, single-entry RX holding register,
// programmable baud divisor. Reads are combinational and side-effect free.
module mcu_uart
  import mcu_uart_pkg::*;
#(
  parameter int unsigned TX_DEPTH    = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel_i,
  input  logic [3:0]  addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        txd_o,
  input  logic        rxd_i,
  output logic        irq_o
);

  // ---------------- bus decode ----------------
  logic acc_wr, wr_tx, wr_rx, wr_st, wr_div;
  assign acc_wr = sel_i & we_i;
  assign wr_tx  = acc_wr && (addr_i[3:2] == OFF_TXDATA[3:2]) && be_i[0];
  assign wr_rx  = acc_wr && (addr_i[3:2] == OFF_RXDATA[3:2]);
  assign wr_st  = acc_wr && (addr_i[3:2] == OFF_STATUS[3:2]) && be_i[0];
  assign wr_div = acc_wr && (addr_i[3:2] == OFF_DIV[3:2]);

  logic unused_bits;
  assign unused_bits = ^{addr_i[1:0], be_i[3:2], wdata_i[31:16]};

  // ---------------- registers ----------------
  logic [15:0] div_q, div_d, div_eff;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_ovr_q, rx_ovr_d, tx_ovf_q, tx_ovf_d, frm_err_q, frm_err_d;

  assign div_eff = eff_div(div_q);

  // ---------------- TX FIFO ----------------
  logic       tx_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_rdata;

  mcu_uart_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (wr_tx),
    .wdata_i (wdata_i[7:0]),
    .pop_i   (tx_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ---------------- TX FSM ----------------
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        txd_q, txd_d, tx_bit_end;

  // Divisor is latched at every bit start so a DIV write only affects the next bit.
  assign tx_bit_end = (tx_cnt_q >= tx_div_q - 16'd1);

  // TX next-state: start bit, 8 data bits LSB first, stop, chaining frames back to back.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 16'd1;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        txd_d    = 1'b1;
        if (!fifo_empty) begin
          tx_pop     = 1'b1;
          tx_sh_d    = fifo_rdata;
          txd_d      = 1'b0;
          tx_div_d   = div_eff;
          tx_state_d = TX_START;
        end
      end
      TX_START: if (tx_bit_end) begin
        tx_cnt_d   = '0;
        tx_div_d   = div_eff;
        tx_bit_d   = '0;
        txd_d      = tx_sh_q[0];
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_bit_end) begin
        tx_cnt_d = '0;
        tx_div_d = div_eff;
        if (tx_bit_q == 3'd7) begin
          txd_d      = 1'b1;
          tx_state_d = TX_STOP;
        end else begin
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          txd_d    = tx_sh_q[1];
          tx_bit_d = tx_bit_q + 3'd1;
        end
      end
      TX_STOP: if (tx_bit_end) begin
        tx_cnt_d = '0;
        tx_div_d = div_eff;
        if (!fifo_empty) begin
          tx_pop     = 1'b1;
          tx_sh_d    = fifo_rdata;
          txd_d      = 1'b0;
          tx_state_d = TX_START;
        end else begin
          txd_d      = 1'b1;
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX state register; reset forces the line idle immediately, aborting any frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= DIV_MIN;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      txd_q      <= txd_d;
    end
  end

  // ---------------- RX FSM ----------------
  logic        rx_s1_q, rx_s2_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_half;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_stop_ok, rx_stop_bad;

  assign rx_half = div_eff >> 1;

  // Two-flop synchronizer for the asynchronous serial input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= rxd_i;
      rx_s2_q <= rx_s1_q;
    end
  end

  // RX next-state: confirm start at half a bit, then sample every full bit from there.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q + 16'd1;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    rx_stop_ok  = 1'b0;
    rx_stop_bad = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s2_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q >= rx_half - 16'd1) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q >= div_eff - 16'd1) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q >= div_eff - 16'd1) begin
        rx_cnt_d    = '0;
        rx_stop_ok  = rx_s2_q;
        rx_stop_bad = !rx_s2_q;
        rx_state_d  = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
    end
  end

  // ---------------- software-visible state ----------------
  // Clears are applied first so that a same-cycle set always wins.
  always_comb begin
    div_d      = div_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    rx_ovr_d   = rx_ovr_q;
    tx_ovf_d   = tx_ovf_q;
    frm_err_d  = frm_err_q;
    if (wr_div && be_i[0]) div_d[7:0]  = wdata_i[7:0];
    if (wr_div && be_i[1]) div_d[15:8] = wdata_i[15:8];
    if (wr_st) begin
      if (wdata_i[ST_RX_OVERRUN])  rx_ovr_d  = 1'b0;
      if (wdata_i[ST_TX_OVERFLOW]) tx_ovf_d  = 1'b0;
      if (wdata_i[ST_FRAME_ERR])   frm_err_d = 1'b0;
    end
    if (wr_rx) rx_valid_d = 1'b0;
    // A same-cycle RXDATA write frees the holding register for the new byte.
    if (rx_stop_ok) begin
      if (!rx_valid_q || wr_rx) begin
        rx_data_d  = rx_sh_q;
        rx_valid_d = 1'b1;
      end else begin
        rx_ovr_d = 1'b1;
      end
    end
    if (rx_stop_bad)          frm_err_d = 1'b1;
    if (wr_tx && fifo_full)   tx_ovf_d  = 1'b1;
  end

  // Register file state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= DEFAULT_DIV;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_ovr_q   <= 1'b0;
      tx_ovf_q   <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      div_q      <= div_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_ovr_q   <= rx_ovr_d;
      tx_ovf_q   <= tx_ovf_d;
      frm_err_q  <= frm_err_d;
    end
  end

  // ---------------- read mux and outputs ----------------
  logic [6:0] status_w;

  // Combinational read data so the core can complete a load in one cycle.
  always_comb begin
    status_w                 = '0;
    status_w[ST_TX_FULL]     = fifo_full;
    status_w[ST_TX_EMPTY]    = fifo_empty;
    status_w[ST_TX_BUSY]     = (tx_state_q != TX_IDLE);
    status_w[ST_RX_VALID]    = rx_valid_q;
    status_w[ST_RX_OVERRUN]  = rx_ovr_q;
    status_w[ST_TX_OVERFLOW] = tx_ovf_q;
    status_w[ST_FRAME_ERR]   = frm_err_q;
    rdata_o = '0;
    if (sel_i && !we_i) begin
      case (addr_i[3:2])
        OFF_RXDATA[3:2]: rdata_o = {23'b0, rx_valid_q, rx_data_q};
        OFF_STATUS[3:2]: rdata_o = {25'b0, status_w};
        OFF_DIV[3:2]:    rdata_o = {16'b0, div_q};
        default:         rdata_o = '0;
      endcase
    end
  end

  assign txd_o = txd_q;
  assign irq_o = rx_valid_q;

endmodule

// File: tb/tb_mcu_uart.sv
// Directed bench for mcu_uart. TX bytes are checked by a line-decoding monitor
// against an expected-byte queue; RX arrivals by an irq monitor against a count.
module tb_mcu_uart;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        sel_i = 1'b0, we_i = 1'b0, rxd_i = 1'b1;
  logic [3:0]  addr_i = 4'h0, be_i = 4'h0;
  logic [31:0] wdata_i = '0, rdata_o;
  logic        txd_o, irq_o;

  mcu_uart #(.TX_DEPTH(4), .DEFAULT_DIV(16'd434)) dut (
    .clk(clk), .rst_n(rst_n), .sel_i(sel_i), .addr_i(addr_i), .we_i(we_i),
    .be_i(be_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .txd_o(txd_o),
    .rxd_i(rxd_i), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0, cur_div = 434, exp_irq = 0;
  logic [7:0] exp_tx [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    sel_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d; be_i = be;
    @(posedge clk); #1;
    sel_i = 1'b0; we_i = 1'b0; be_i = 4'h0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    sel_i = 1'b1; we_i = 1'b0; addr_i = a;
    #1 d = rdata_o;
    sel_i = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input int div);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); rxd_i = fr[i];
      repeat (div - 1) @(negedge clk);
    end
    @(negedge clk); rxd_i = 1'b1;
    repeat (div) @(negedge clk);
  endtask

  // TX monitor: decode each frame mid-bit and compare with the next expected byte.
  int         mon_st = 0, mon_pos = 0;
  logic [7:0] mon_sh = '0;
  logic       mon_bad = 1'b0;
  logic [7:0] mon_exp;
  initial begin : tx_mon
    forever begin
      @(posedge clk); #2;
      if (!rst_n) begin
        mon_st = 0; mon_bad = 1'b0;
      end else if (mon_st == 0) begin
        if (txd_o === 1'b0) begin mon_st = 1; mon_pos = 0; end
      end else begin
        mon_pos++;
        if (mon_pos % cur_div == cur_div / 2) begin
          if (mon_pos / cur_div == 0) begin
            if (txd_o !== 1'b0) mon_bad = 1'b1;
          end else if (mon_pos / cur_div <= 8) begin
            mon_sh[mon_pos / cur_div - 1] = txd_o;
          end else begin
            checks++;
            if (exp_tx.size() == 0) begin
              failures++;
              $display("FAIL tx_frame: got byte 0x%0h but none expected", mon_sh);
            end else begin
              mon_exp = exp_tx.pop_front();
              if (mon_sh !== mon_exp || txd_o !== 1'b1 || mon_bad) begin
                failures++;
                $display("FAIL tx_frame: got 0x%0h stop=%b startbad=%b expected 0x%0h stop=1",
                         mon_sh, txd_o, mon_bad, mon_exp);
              end
            end
            mon_st = 0; mon_bad = 1'b0;
          end
        end
      end
    end
  end

  // irq monitor: every rising irq_o must correspond to an expected received byte.
  logic irq_prev = 1'b0;
  initial begin : irq_mon
    forever begin
      @(posedge clk); #2;
      if (irq_o === 1'b1 && irq_prev === 1'b0) begin
        checks++;
        if (exp_irq > 0) exp_irq--;
        else begin
          failures++;
          $display("FAIL irq_rise: got unexpected irq expected none");
        end
      end
      irq_prev = irq_o;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  logic [31:0] d;
  logic [9:0]  fr;
  logic        full_seen, low_seen;
  int          c0, n;

  initial begin
    // 1. reset state
    repeat (3) @(negedge clk);
    chk("rst_txd_in_reset", {31'b0, txd_o}, 32'h1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_txd", {31'b0, txd_o}, 32'h1);
    chk("rst_irq", {31'b0, irq_o}, 32'h0);
    rd(4'h8, d); chk("rst_status", d, 32'h2);
    rd(4'hC, d); chk("rst_div", d, 32'd434);
    rd(4'h4, d); chk("rst_rxdata", d, 32'h0);
    rd(4'h0, d); chk("rst_txdata_rd", d, 32'h0);

    // 2. single frame 0xA5 at DIV=4, exact per-cycle line levels
    wr(4'hC, 32'd4, 4'b0011); cur_div = 4;
    rd(4'hC, d); chk("div_wr", d, 32'd4);
    exp_tx.push_back(8'hA5);
    wr(4'h0, 32'hA5, 4'b0001);
    chk("tx_before_pop", {31'b0, txd_o}, 32'h1);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      chk("tx_level", {31'b0, txd_o}, {31'b0, fr[k / 4]});
      rd(4'h8, d); chk("tx_busy", {31'b0, d[2]}, 32'h1);
    end
    @(posedge clk); #1;
    rd(4'h8, d); chk("tx_done_status", d, 32'h2);
    chk("tx_done_txd", {31'b0, txd_o}, 32'h1);

    // 3. six back-to-back writes: five sent gap-free, sixth dropped
    full_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sel_i = 1'b1; we_i = 1'b0; addr_i = 4'h8;
      #1 if (rdata_o[0]) full_seen = 1'b1;
      we_i = 1'b1; addr_i = 4'h0; wdata_i = i + 1; be_i = 4'b0001;
      if (i < 5) exp_tx.push_back(8'(i + 1));
      @(posedge clk); #1;
      if (i == 0) c0 = cyc;
    end
    sel_i = 1'b0; we_i = 1'b0; be_i = 4'h0;
    chk("burst_full_seen", {31'b0, full_seen}, 32'h1);
    rd(4'h8, d); chk("burst_overflow", {31'b0, d[5]}, 32'h1);
    n = 0;
    do begin
      @(posedge clk); #1; rd(4'h8, d); n++;
    end while (d[2] && n < 400);
    chk("burst_span", cyc - c0, 32'd201);
    chk("burst_queue_drained", exp_tx.size(), 32'd0);
    wr(4'h8, 32'h20, 4'b0001);
    rd(4'h8, d); chk("burst_w1c", d, 32'h2);

    // 4. receive 0x3C at DIV=8, then pop it
    wr(4'hC, 32'd8, 4'b0011); cur_div = 8;
    exp_irq++;
    send_rx(8'h3C, 1'b1, 8);
    chk("rx_irq", {31'b0, irq_o}, 32'h1);
    rd(4'h4, d); chk("rx_data", d, 32'h13C);
    wr(4'h4, 32'h0, 4'b0000);
    chk("rx_irq_clr", {31'b0, irq_o}, 32'h0);
    rd(4'h4, d); chk("rx_data_kept", d, 32'h03C);

    // 5. overrun, frame error, glitch rejection
    exp_irq++;
    send_rx(8'h3C, 1'b1, 8);
    send_rx(8'h55, 1'b1, 8);
    rd(4'h8, d); chk("rx_overrun_status", d, 32'h1A);
    rd(4'h4, d); chk("rx_overrun_data", d, 32'h13C);
    send_rx(8'hA5, 1'b0, 8);
    rd(4'h8, d); chk("rx_frame_err", d, 32'h5A);
    @(negedge clk); rxd_i = 1'b0;
    repeat (2) @(negedge clk); rxd_i = 1'b1;
    repeat (40) @(negedge clk);
    rd(4'h8, d); chk("rx_glitch_status", d, 32'h5A);
    rd(4'h4, d); chk("rx_glitch_data", d, 32'h13C);
    wr(4'h8, 32'h50, 4'b0001);
    rd(4'h8, d); chk("rx_w1c", d, 32'h0A);

    // 6. reset mid-frame with three bytes queued
    wr(4'hC, 32'd4, 4'b0011); cur_div = 4;
    for (int i = 0; i < 4; i++) wr(4'h0, 32'h11 + i, 4'b0001);
    repeat (8) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("mid_rst_txd", {31'b0, txd_o}, 32'h1);
    chk("mid_rst_irq", {31'b0, irq_o}, 32'h0);
    repeat (2) @(negedge clk);
    cur_div = 434;
    rst_n = 1'b1;
    @(negedge clk);
    rd(4'h8, d); chk("post_rst_status", d, 32'h2);
    rd(4'hC, d); chk("post_rst_div", d, 32'd434);
    low_seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (txd_o !== 1'b1) low_seen = 1'b1;
    end
    chk("post_rst_line_idle", {31'b0, low_seen}, 32'h0);

    repeat (5) @(posedge clk);
    chk("tx_queue_empty", exp_tx.size(), 32'd0);
    chk("irq_all_seen", exp_irq, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
